feature_frame_loader: RTL

Front-end driver for the combinational binary classifier netlists (49-bit feature vector in, 2-bit class scores out). It assembles a binary image streamed as rows, presents it as a stable feature vector, waits a fixed settle time, then captures the network's scores into a class decision. The result is returned through a valid/ready result port. The classifier instance is external; this block drives its input vector and samples its output bits.

---
 rtl/feature_frame_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/feature_frame_loader.sv
// Streams a binary image in row by row, holds it as a stable feature vector for an
// external combinational classifier, then latches the classifier scores as a result.
module feature_frame_loader #(
  parameter int ROW_W       = 7,
  parameter int NUM_ROWS    = 7,
  parameter int EVAL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [ROW_W-1:0]          row_data,
  input  logic                      row_last,
  output logic [ROW_W*NUM_ROWS-1:0] feat_bits,
  output logic                      feat_valid,
  input  logic [1:0]                net_bits,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_class,
  output logic [1:0]                res_scores,
  output logic                      res_tie,
  output logic                      frame_err,
  output logic [CNT_W-1:0]          frames_done
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int EW = $clog2(EVAL_CYCLES + 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [EW-1:0] EVAL_LOAD = EW'(EVAL_CYCLES);

  typedef enum logic [1:0] {LOAD, EVAL, RESULT} state_t;

  state_t          state;
  logic [RW-1:0]   row_idx;
  logic [EW-1:0]   eval_cnt;

  // Handshakes: a beat/result transfers on the rising edge where valid && ready.
  assign row_ready = (state == LOAD) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      row_idx     <= '0;
      eval_cnt    <= '0;
      feat_bits   <= '0;
      feat_valid  <= 1'b0;
      res_valid   <= 1'b0;
      res_class   <= 1'b0;
      res_scores  <= 2'b00;
      res_tie     <= 1'b0;
      frame_err   <= 1'b0;
      frames_done <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          if (row_valid) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
              if (row_idx == RW'(r)) feat_bits[r*ROW_W +: ROW_W] <= row_data;
            end
            if (row_last && row_idx == LAST_ROW) begin
              row_idx    <= '0;
              eval_cnt   <= EVAL_LOAD;
              feat_valid <= 1'b1;
              state      <= EVAL;
            end else if (row_last || row_idx == LAST_ROW) begin
              // Short or overlong frame: drop it, keep stale rows for the next frame to overwrite.
              frame_err <= 1'b1;
              row_idx   <= '0;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        EVAL: begin
          if (eval_cnt == EW'(1)) begin
            res_scores <= net_bits;
            res_class  <= (net_bits == 2'b10);
            res_tie    <= (net_bits[0] == net_bits[1]);
            res_valid  <= 1'b1;
            state      <= RESULT;
          end
          eval_cnt <= eval_cnt - 1'b1;
        end
        RESULT: begin
          if (res_ready) begin
            frames_done <= frames_done + 1'b1;
            res_valid   <= 1'b0;
            feat_valid  <= 1'b0;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
